// File: rtl/inv_mix_columns_if.sv
// Handshake bundle for the InvMixColumns block: one 128-bit AES state in and one out.
// The slave modport is the transform block and the master modport is its environment.
interface inv_mix_columns_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a 128-bit state, processing COLS_PER_CYCLE columns per clock.
// The result stays in the working register, which drives out_data directly.
module inv_mix_columns #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   inv_mix_columns_if.slave  bus,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [1:0]        col;
   logic [3:0][31:0]  work;
   logic [3:0][31:0]  next_work;
   logic              out_valid;
   logic              last;
   logic              accept;

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("inv_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Each coefficient is a sum of s, 2s, 4s and 8s, built from a chain of three xtimes.
   function automatic logic [31:0] inv_column(input logic [31:0] c);
      logic [7:0] s  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         s[i]  = c[31-8*i -: 8];
         x2    = xtime(s[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ s[i];
         mb[i] = x8 ^ x2 ^ s[i];
         md[i] = x8 ^ x4 ^ s[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Column c lives in work[3-c], i.e. work[~c], so column 0 lands in the MSBs.
   always_comb begin
      next_work = work;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         next_work[~(col + 2'(k))] = inv_column(work[~(col + 2'(k))]);
      end
   end

   assign last          = (col + 2'(COLS_PER_CYCLE - 1)) == 2'd3;
   assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = work;

   // A DONE state with both handshakes reloads straight into RUN, so streaming has no bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         col       <= 2'd0;
         work      <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work  <= bus.in_data;
                  col   <= 2'd0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               work <= next_work;
               col  <= col + 2'(COLS_PER_CYCLE);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  if (accept) begin
                     work  <= bus.in_data;
                     col   <= 2'd0;
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Bench for inv_mix_columns: three instances (1, 2 and 4 columns per clock) checked
// against a GF(2^8) matrix model built on polynomial multiplication.
module tb_inv_mix_columns;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid_a  [3];
   logic [127:0] in_data_a   [3];
   logic         out_ready_a [3];
   logic         in_ready_a  [3];
   logic         out_valid_a [3];
   logic [127:0] out_data_a  [3];
   logic         busy_a      [3];

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   inv_mix_columns_if bus_arr[3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign bus_arr[g].in_valid  = in_valid_a[g];
      assign bus_arr[g].in_data   = in_data_a[g];
      assign bus_arr[g].out_ready = out_ready_a[g];
      assign in_ready_a[g]        = bus_arr[g].in_ready;
      assign out_valid_a[g]       = bus_arr[g].out_valid;
      assign out_data_a[g]        = bus_arr[g].out_data;

      inv_mix_columns #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk  (clk),
         .rst  (rst),
         .bus  (bus_arr[g]),
         .busy (busy_a[g])
      );
   end

   // Schoolbook carry-less product followed by reduction modulo 0x11b.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] mixModel(input logic [127:0] s, input bit inverse);
      logic [7:0]   row [4];
      logic [7:0]   o;
      logic [127:0] r;
      if (inverse) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else         row = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            o = 8'h00;
            for (int k = 0; k < 4; k++)
               o = o ^ gfMul(row[(k - rr + 4) % 4], s[127 - 32*c - 8*k -: 8]);
            r[127 - 32*c - 8*rr -: 8] = o;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] randState();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // One transaction on instance d: junk in_valid during RUN/DONE must not be captured.
   task automatic applyStimulus(input int d, input logic [127:0] din, input logic [127:0] expv, input string tag);
      int cycles;
      in_valid_a[d]  = 1'b1;
      in_data_a[d]   = din;
      out_ready_a[d] = 1'b0;
      tick();
      in_data_a[d] = randState();
      cycles = 0;
      while (!out_valid_a[d] && cycles < 20) begin
         tick();
         cycles++;
      end
      in_valid_a[d] = 1'b0;
      checkOutput({tag, " latency"}, 128'(cycles), 128'(4 >> d));
      checkOutput({tag, " data"}, out_data_a[d], expv);
      out_ready_a[d] = 1'b1;
      tick();
      out_ready_a[d] = 1'b0;
      checkOutput({tag, " out_valid after drain"}, 128'(out_valid_a[d]), 128'(0));
      checkOutput({tag, " busy after drain"}, 128'(busy_a[d]), 128'(0));
   endtask

   task automatic runStream(input int d, input int n, input bit round_trip, input string tag);
      logic [127:0] orig [$];
      logic [127:0] expq [$];
      int sent, got, cyc, last_cyc;
      bit hs_in, hs_out;
      sent = 0; got = 0; cyc = 0; last_cyc = 0;
      for (int i = 0; i < n; i++) orig.push_back(randState());
      out_ready_a[d] = 1'b1;
      in_valid_a[d]  = 1'b1;
      in_data_a[d]   = round_trip ? mixModel(orig[0], 1'b0) : orig[0];
      while (got < n && cyc < n * 8 + 20) begin
         #1;
         hs_in  = in_valid_a[d] && in_ready_a[d];
         hs_out = out_valid_a[d] && out_ready_a[d];
         if (hs_out) begin
            checkOutput({tag, " data"}, out_data_a[d], expq.pop_front());
            if (got > 0) checkOutput({tag, " period"}, 128'(cyc - last_cyc), 128'((4 >> d) + 1));
            last_cyc = cyc;
            got++;
         end
         if (hs_in) begin
            expq.push_back(round_trip ? orig[sent] : mixModel(orig[sent], 1'b1));
            sent++;
         end
         tick();
         cyc++;
         if (hs_in) begin
            if (sent < n) in_data_a[d] = round_trip ? mixModel(orig[sent], 1'b0) : orig[sent];
            else          in_valid_a[d] = 1'b0;
         end
      end
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b0;
      checkOutput({tag, " result count"}, 128'(got), 128'(n));
   endtask

   initial begin
      logic [127:0] bp_in, bp_exp;
      int cycles;

      for (int d = 0; d < 3; d++) begin
         in_valid_a[d]  = 1'b1;
         in_data_a[d]   = randState();
         out_ready_a[d] = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         checkOutput("reset out_valid", 128'(out_valid_a[d]), 128'(0));
         checkOutput("reset busy", 128'(busy_a[d]), 128'(0));
         checkOutput("reset in_ready", 128'(in_ready_a[d]), 128'(1));
         checkOutput("reset out_data", out_data_a[d], 128'h0);
         in_valid_a[d] = 1'b0;
      end
      rst = 1'b0;

      applyStimulus(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                       128'hdb135345_f20a225c_01010101_c6c6c6c6, "ka cols1");
      applyStimulus(1, 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_00000000,
                       128'hd4d4d4d5_2d26314c_db135345_00000000, "ka cols2");
      applyStimulus(2, 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_00000000,
                       128'hd4d4d4d5_2d26314c_db135345_00000000, "ka cols4");

      // Backpressure: result must hold while the consumer stalls, even with a new input offered.
      bp_in  = randState();
      bp_exp = mixModel(bp_in, 1'b1);
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = bp_in;
      tick();
      in_data_a[0] = randState();
      cycles = 0;
      while (!out_valid_a[0] && cycles < 20) begin
         tick();
         cycles++;
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput("backpressure out_valid", 128'(out_valid_a[0]), 128'(1));
         checkOutput("backpressure out_data", out_data_a[0], bp_exp);
         checkOutput("backpressure in_ready", 128'(in_ready_a[0]), 128'(0));
         tick();
      end
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      tick();
      out_ready_a[0] = 1'b0;
      #1;
      checkOutput("backpressure drain out_valid", 128'(out_valid_a[0]), 128'(0));
      checkOutput("backpressure drain in_ready", 128'(in_ready_a[0]), 128'(1));

      runStream(0, 8, 1'b0, "stream cols1");
      runStream(1, 8, 1'b0, "stream cols2");
      runStream(2, 8, 1'b0, "stream cols4");

      // Abort after two columns: busy must drop before any clock edge.
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = randState();
      tick();
      in_valid_a[0] = 1'b0;
      tick();
      tick();
      checkOutput("mid-run busy before reset", 128'(busy_a[0]), 128'(1));
      rst = 1'b1;
      #1;
      checkOutput("mid-run reset busy", 128'(busy_a[0]), 128'(0));
      checkOutput("mid-run reset out_valid", 128'(out_valid_a[0]), 128'(0));
      checkOutput("mid-run reset out_data", out_data_a[0], 128'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("post-reset out_valid", 128'(out_valid_a[0]), 128'(0));
      end
      applyStimulus(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                       128'hdb135345_f20a225c_01010101_c6c6c6c6, "ka after reset");

      runStream(0, 1000, 1'b1, "round trip cols1");
      runStream(1, 100, 1'b1, "round trip cols2");
      runStream(2, 100, 1'b1, "round trip cols4");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
